// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation-select encodings.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_frame_cnt.sv
// Modulo-Depth shift counter with a registered wrap pulse, reusable by any serialiser.
module usr_frame_cnt #(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            wrap_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            wrap_d, wrap_q;
  logic            at_last;

  assign at_last = (cnt_q == CntW'(Depth - 1));

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d  = at_last ? '0 : cnt_q + CntW'(1);
      wrap_d = at_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/usr_shift_reg.sv
// Parametrised universal shift register (hold / shift right / shift left / load).
// Define USR_ROTATE_EN to add the rot_i port, which recirculates the exiting stage on shifts.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [1:0]                 mode_i,
  input  logic [WIDTH-1:0]           sin_r_i,
  input  logic [WIDTH-1:0]           sin_l_i,
  input  logic [DEPTH*WIDTH-1:0]     pin_i,
`ifdef USR_ROTATE_EN
  input  logic                       rot_i,
`endif
  output logic [WIDTH-1:0]           sout_r_o,
  output logic [WIDTH-1:0]           sout_l_o,
  output logic [DEPTH*WIDTH-1:0]     pout_o,
  output logic [$clog2(DEPTH)-1:0]   shift_cnt_o,
  output logic                       frame_done_o
);

  localparam int unsigned CntW = $clog2(DEPTH);

  logic [DEPTH*WIDTH-1:0] stages;
  logic [WIDTH-1:0]       shr_in, shl_in;
  logic                   do_shift, do_load;

  assign do_shift = en_i && ((mode_i == MODE_SHR) || (mode_i == MODE_SHL));
  assign do_load  = en_i && (mode_i == MODE_LOAD);

  always_comb begin
    shr_in = sin_r_i;
    shl_in = sin_l_i;
`ifdef USR_ROTATE_EN
    if (rot_i) begin
      shr_in = stages[WIDTH-1:0];
      shl_in = stages[DEPTH*WIDTH-1 -: WIDTH];
    end
`endif
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d, stage_q;
    logic [WIDTH-1:0] from_right, from_left;

    if (i == DEPTH - 1) begin : g_top
      assign from_right = shr_in;
    end else begin : g_mid_r
      assign from_right = stages[(i+1)*WIDTH +: WIDTH];
    end

    if (i == 0) begin : g_bot
      assign from_left = shl_in;
    end else begin : g_mid_l
      assign from_left = stages[(i-1)*WIDTH +: WIDTH];
    end

    always_comb begin
      stage_d = stage_q;
      if (en_i) begin
        unique case (mode_i)
          MODE_HOLD: stage_d = stage_q;
          MODE_SHR:  stage_d = from_right;
          MODE_SHL:  stage_d = from_left;
          MODE_LOAD: stage_d = pin_i[i*WIDTH +: WIDTH];
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign stages[i*WIDTH +: WIDTH] = stage_q;
  end

  usr_frame_cnt #(
    .Depth (DEPTH),
    .CntW  (CntW)
  ) u_frame_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (do_shift),
    .clr_i  (do_load),
    .cnt_o  (shift_cnt_o),
    .wrap_o (frame_done_o)
  );

  assign pout_o   = stages;
  assign sout_r_o = stages[WIDTH-1:0];
  assign sout_l_o = stages[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg: directed scenarios plus random traffic vs. a word model.
module tb_usr_shift_reg;
  import usr_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = WIDTH * DEPTH;

  logic             clk;
  logic             rst, en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] sin_r, sin_l;
  logic [DW-1:0]    pin;
  logic             rot;
  logic [WIDTH-1:0] sout_r, sout_l;
  logic [DW-1:0]    pout;
  logic [1:0]       shift_cnt;
  logic             frame_done;

  // Reference state: whole register as one word, count as a plain integer.
  logic [DW-1:0] m_word;
  int            m_cnt;
  logic          m_fd;

  int n_vec  = 0;
  int n_fail = 0;

  usr_shift_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .mode_i       (mode),
    .sin_r_i      (sin_r),
    .sin_l_i      (sin_l),
    .pin_i        (pin),
`ifdef USR_ROTATE_EN
    .rot_i        (rot),
`endif
    .sout_r_o     (sout_r),
    .sout_l_o     (sout_l),
    .pout_o       (pout),
    .shift_cnt_o  (shift_cnt),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0]    ext;
    logic [WIDTH-1:0] in_v;
    bit               shifted;
    shifted = 0;
    m_fd    = 1'b0;
    if (rst) begin
      m_word = '0;
      m_cnt  = 0;
    end else if (en) begin
      if (mode == MODE_SHR) begin
        in_v    = rot ? m_word[WIDTH-1:0] : sin_r;
        ext     = DW'(in_v);
        m_word  = (m_word >> WIDTH) | (ext << ((DEPTH - 1) * WIDTH));
        shifted = 1;
      end else if (mode == MODE_SHL) begin
        in_v    = rot ? m_word[DW-1 -: WIDTH] : sin_l;
        ext     = DW'(in_v);
        m_word  = (m_word << WIDTH) | ext;
        shifted = 1;
      end else if (mode == MODE_LOAD) begin
        m_word = pin;
        m_cnt  = 0;
      end
      if (shifted) begin
        m_cnt = (m_cnt + 1) % DEPTH;
        m_fd  = (m_cnt == 0);
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [WIDTH-1:0] sr, input logic [WIDTH-1:0] sl,
                      input logic [DW-1:0] p, input logic rt);
    rst   = r;
    en    = e;
    mode  = md;
    sin_r = sr;
    sin_l = sl;
    pin   = p;
    rot   = rt;
    @(posedge clk);
    model_edge();
    #1;
    check_val("pout", 64'(pout), 64'(m_word));
    check_val("sout_r", 64'(sout_r), 64'(m_word[WIDTH-1:0]));
    check_val("sout_l", 64'(sout_l), 64'(m_word[DW-1 -: WIDTH]));
    check_val("shift_cnt", 64'(shift_cnt), 64'(m_cnt));
    check_val("frame_done", 64'(frame_done), 64'(m_fd));
  endtask

  initial begin
    logic [7:0] siso_bits [4];
    logic [7:0] piso_exp  [4];
    siso_bits = '{8'd1, 8'd0, 8'd1, 8'd1};
    piso_exp  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    m_word = '0; m_cnt = 0; m_fd = 1'b0;

    // Reset overrides an asserted LOAD.
    step(1, 0, MODE_HOLD, 0, 0, 0, 0);
    step(0, 1, MODE_LOAD, 0, 0, 32'h12345678, 0);
    step(1, 1, MODE_LOAD, 0, 0, 32'hFFFFFFFF, 0);
    check_val("rst_pout", 64'(pout), 64'h0);
    check_val("rst_cnt", 64'(shift_cnt), 64'h0);
    check_val("rst_fd", 64'(frame_done), 64'h0);

    // SISO right shift.
    for (int i = 0; i < 4; i++) step(0, 1, MODE_SHR, siso_bits[i], 0, 0, 0);
    check_val("siso_pout", 64'(pout), 64'h01010001);
    check_val("siso_fd", 64'(frame_done), 64'h1);
    for (int i = 0; i < 4; i++) begin
      check_val("siso_sout_r", 64'(sout_r), 64'(siso_bits[i]));
      step(0, 1, MODE_SHR, 0, 0, 0, 0);
    end

    // PISO left shift.
    step(0, 1, MODE_LOAD, 0, 0, 32'hDDCCBBAA, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("piso_sout_l", 64'(sout_l), 64'(piso_exp[i]));
      step(0, 1, MODE_SHL, 0, 0, 0, 0);
    end
    check_val("piso_pout", 64'(pout), 64'h0);
    check_val("piso_fd", 64'(frame_done), 64'h1);

    // Enable gating: 4 enabled shifts over 7 cycles.
    step(0, 1, MODE_LOAD, 0, 0, 32'h0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, (i % 2) == 0, MODE_SHR, 8'h5A, 0, 0, 0);
      if (i < 6) check_val("gate_nofd", 64'(frame_done), 64'h0);
    end
    check_val("gate_fd", 64'(frame_done), 64'h1);

    // LOAD at count 3 suppresses the wrap.
    for (int i = 0; i < 3; i++) step(0, 1, MODE_SHL, 8'h3C, 0, 0, 0);
    check_val("bnd_cnt3", 64'(shift_cnt), 64'h3);
    step(0, 1, MODE_LOAD, 0, 0, 32'hA5A5A5A5, 0);
    check_val("bnd_load_fd", 64'(frame_done), 64'h0);
    check_val("bnd_load_cnt", 64'(shift_cnt), 64'h0);

    // Reset at count 2 discards the partial frame.
    for (int i = 0; i < 2; i++) step(0, 1, MODE_SHR, 8'h11, 0, 0, 0);
    step(1, 1, MODE_SHR, 8'h22, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, MODE_SHR, 8'h33, 0, 0, 0);
      check_val("bnd_rst_fd", 64'(frame_done), (i == 3) ? 64'h1 : 64'h0);
    end

`ifdef USR_ROTATE_EN
    step(0, 1, MODE_LOAD, 0, 0, 32'h04030201, 0);
    for (int i = 0; i < 4; i++) step(0, 1, MODE_SHR, 8'hEE, 0, 0, 1);
    check_val("rot_pout", 64'(pout), 64'h04030201);
    check_val("rot_fd", 64'(frame_done), 64'h1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic rt;
      rt = 1'b0;
`ifdef USR_ROTATE_EN
      rt = 1'($urandom_range(0, 1));
`endif
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 32'($urandom), rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
